// File: rtl/avg_pkg.sv
// Shared types and helpers for the vector averaging scheduler.
package avg_pkg;

    // Fixed-point rounding mode
    typedef enum logic [1:0] {
        VXRM_RNU = 2'd0,
        VXRM_RNE = 2'd1,
        VXRM_RDN = 2'd2,
        VXRM_ROD = 2'd3
    } vxrm_t;

    localparam int unsigned SEW_W = 2;

    localparam logic [1:0] SEW8  = 2'd0;
    localparam logic [1:0] SEW16 = 2'd1;
    localparam logic [1:0] SEW32 = 2'd2;
    localparam logic [1:0] SEW64 = 2'd3;

    // Rounding increment from result LSB (b1) and the bit shifted out (b0)
    function automatic logic rnd_inc(input vxrm_t vxrm, input logic b1, input logic b0);
        logic r;
        r = 1'b0;
        case (vxrm)
            VXRM_RNU: r = b0;
            VXRM_RNE: r = b0 & b1;
            VXRM_RDN: r = 1'b0;
            VXRM_ROD: r = b0 & ~b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/avg_out_fifo.sv
// Small synchronous FIFO with async reset and registered occupancy count.
module avg_out_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avg_unit.sv
// Averaging core: per-element logical shift right of the pre-summed vector,
// exporting the two low bits of every element for the rounding stage.
// Outputs are registered one cycle after vec_in; no reset on the datapath.
module avg_unit
    import avg_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 64,
    parameter  bit          ENABLE_64_BIT = 1'b1,
    localparam int unsigned DW_B          = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] vec_in,
    input  logic [1:0]            sew,
    output logic [DATA_WIDTH-1:0] vec_out,
    output logic [DW_B-1:0]       v_d,
    output logic [DW_B-1:0]       v_d1
);

    logic [DATA_WIDTH-1:0] shr_c;
    logic [DW_B-1:0]       vd_c;
    logic [DW_B-1:0]       vd1_c;
    logic                  zero_c;

    assign zero_c = (sew == SEW64) && !ENABLE_64_BIT;

    // Per-element shift and low-bit extraction (element LSB sits in its lowest byte)
    always_comb begin
        shr_c = '0;
        vd_c  = '0;
        vd1_c = '0;
        if (!zero_c) begin
            for (int j = 0; j < int'(DW_B); j++) begin
                vd_c[j]  = vec_in[j*8+1];
                vd1_c[j] = vec_in[j*8];
            end
        end
        case (sew)
            SEW8: begin
                for (int k = 0; k < int'(DATA_WIDTH / 8); k++)
                    shr_c[k*8 +: 8] = {1'b0, vec_in[k*8+1 +: 7]};
            end
            SEW16: begin
                for (int k = 0; k < int'(DATA_WIDTH / 16); k++)
                    shr_c[k*16 +: 16] = {1'b0, vec_in[k*16+1 +: 15]};
            end
            SEW32: begin
                for (int k = 0; k < int'(DATA_WIDTH / 32); k++)
                    shr_c[k*32 +: 32] = {1'b0, vec_in[k*32+1 +: 31]};
            end
            default: begin
                if (!zero_c) begin
                    for (int k = 0; k < int'(DATA_WIDTH / 64); k++)
                        shr_c[k*64 +: 64] = {1'b0, vec_in[k*64+1 +: 63]};
                end
            end
        endcase
    end

    // Output register stage
    always_ff @(posedge clk) begin
        vec_out <= shr_c;
        v_d     <= vd_c;
        v_d1    <= vd1_c;
    end

endmodule

// File: rtl/avg_sched.sv
// Round-robin scheduler and rounding back-end for the vector averaging unit.
// Credits (FIFO occupancy + in-flight op) gate issue so results are never dropped.
module avg_sched
    import avg_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 64,
    parameter  int unsigned DW_B          = DATA_WIDTH / 8,
    parameter  int unsigned SEW_WIDTH     = SEW_W,
    parameter  bit          ENABLE_64_BIT = 1'b1,
    parameter  int unsigned NUM_REQ       = 2,
    parameter  int unsigned FIFO_DEPTH    = 3,
    parameter  int unsigned ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SEW_WIDTH-1:0]  req_sew,
    input  logic [NUM_REQ*2-1:0]          req_vxrm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_id
);

    logic [ID_W-1:0]       rr_ptr;
    logic                  inflight;
    logic [ID_W-1:0]       tag_id;
    logic [1:0]            tag_sew;
    vxrm_t                 tag_vxrm;

    logic                  found_c;
    logic [ID_W-1:0]       grant_id_c;
    int                    arb_idx;
    logic                  may_issue_c;
    logic                  issue_c;
    logic [DATA_WIDTH-1:0] op_data_c;
    logic [1:0]            op_sew_c;
    vxrm_t                 op_vxrm_c;

    logic [DATA_WIDTH-1:0] avg_vec;
    logic [DW_B-1:0]       avg_vd;
    logic [DW_B-1:0]       avg_vd1;
    logic [DATA_WIDTH-1:0] res_c;

    logic [CNT_W-1:0]           fifo_count;
    logic [DATA_WIDTH+ID_W-1:0] fifo_rdata;
    logic                       pop_c;

    // Credit check on registered state only (no path from out_ready)
    assign may_issue_c = (int'(fifo_count) + int'(inflight)) < int'(FIFO_DEPTH);

    // Find first valid requester at or after rr_ptr, wrapping
    always_comb begin
        found_c    = 1'b0;
        grant_id_c = '0;
        arb_idx    = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= int'(NUM_REQ)) arb_idx = arb_idx - int'(NUM_REQ);
            if (!found_c && req_valid[ID_W'(arb_idx)]) begin
                found_c    = 1'b1;
                grant_id_c = ID_W'(arb_idx);
            end
        end
    end

    // One-hot grant, suppressed during reset and without credit
    always_comb begin
        req_ready = '0;
        if (found_c && may_issue_c && !rst) req_ready[grant_id_c] = 1'b1;
    end

    assign issue_c = |req_ready;

    // Operand mux for the granted requester
    always_comb begin
        op_data_c = '0;
        op_sew_c  = SEW8;
        op_vxrm_c = VXRM_RNU;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ID_W'(i) == grant_id_c) begin
                op_data_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                op_sew_c  = 2'(req_sew[i*SEW_WIDTH +: SEW_WIDTH]);
                op_vxrm_c = vxrm_t'(req_vxrm[i*2 +: 2]);
            end
        end
    end

    avg_unit #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ENABLE_64_BIT (ENABLE_64_BIT)
    ) u_avg (
        .clk     (clk),
        .vec_in  (op_data_c),
        .sew     (op_sew_c),
        .vec_out (avg_vec),
        .v_d     (avg_vd),
        .v_d1    (avg_vd1)
    );

    // Issue bookkeeping: round-robin pointer and tag of the in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            inflight <= 1'b0;
            tag_id   <= '0;
            tag_sew  <= SEW8;
            tag_vxrm <= VXRM_RNU;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                tag_id   <= grant_id_c;
                tag_sew  <= op_sew_c;
                tag_vxrm <= op_vxrm_c;
                rr_ptr   <= (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + 1'b1;
            end
        end
    end

    // Per-element rounding increment; elements are independent, no carry between them
    always_comb begin
        res_c = '0;
        case (tag_sew)
            SEW8: begin
                for (int k = 0; k < int'(DATA_WIDTH / 8); k++)
                    res_c[k*8 +: 8] = avg_vec[k*8 +: 8]
                        + 8'(rnd_inc(tag_vxrm, avg_vd[k], avg_vd1[k]));
            end
            SEW16: begin
                for (int k = 0; k < int'(DATA_WIDTH / 16); k++)
                    res_c[k*16 +: 16] = avg_vec[k*16 +: 16]
                        + 16'(rnd_inc(tag_vxrm, avg_vd[k*2], avg_vd1[k*2]));
            end
            SEW32: begin
                for (int k = 0; k < int'(DATA_WIDTH / 32); k++)
                    res_c[k*32 +: 32] = avg_vec[k*32 +: 32]
                        + 32'(rnd_inc(tag_vxrm, avg_vd[k*4], avg_vd1[k*4]));
            end
            default: begin
                for (int k = 0; k < int'(DATA_WIDTH / 64); k++)
                    res_c[k*64 +: 64] = avg_vec[k*64 +: 64]
                        + 64'(rnd_inc(tag_vxrm, avg_vd[k*8], avg_vd1[k*8]));
            end
        endcase
    end

    assign pop_c = out_valid && out_ready;

    avg_out_fifo #(
        .WIDTH (DATA_WIDTH + ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .wdata ({res_c, tag_id}),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_rdata[ID_W +: DATA_WIDTH];
    assign out_id    = fifo_rdata[ID_W-1:0];

endmodule

// File: tb/tb_avg_sched.sv
// Directed bench for avg_sched: rounding modes, element widths, round-robin,
// credit backpressure and asynchronous reset.
module tb_avg_sched;
    import avg_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   req_sew;
    logic [3:0]   req_vxrm;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [0:0]   out_id;

    int errors = 0;
    int checks = 0;

    avg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_sew   (req_sew),
        .req_vxrm  (req_vxrm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated request; checks grant, t+1 quiet, t+2 result
    task automatic do_single(input int id, input logic [63:0] data, input logic [1:0] sew,
                             input logic [1:0] vxrm, input logic [63:0] exp, input string tag);
        req_valid              = '0;
        req_valid[id]          = 1'b1;
        req_data[id*64 +: 64]  = data;
        req_sew[id*2 +: 2]     = sew;
        req_vxrm[id*2 +: 2]    = vxrm;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(2'b01 << id));
        @(posedge clk); #1;
        req_valid = '0;
        check({tag, "_t1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_t2_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_id"}, 64'(out_id), 64'(id));
        @(posedge clk); #1;
    endtask

    logic [63:0] cd [3];
    logic [63:0] ce [3];
    int g;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        cd[0] = 64'h10; cd[1] = 64'h21; cd[2] = 64'h32;
        ce[0] = 64'h08; ce[1] = 64'h11; ce[2] = 64'h19;

        rst = 1'b1; req_valid = '0; req_data = '0; req_sew = '0; req_vxrm = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b11;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_id", 64'(out_id), 64'd0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Rounding modes on bytes 03,01,FF,00
        do_single(0, 64'h0000_0000_00FF_0103, SEW8, VXRM_RNU, 64'h0000_0000_0080_0102, "rnu");
        do_single(0, 64'h0000_0000_00FF_0103, SEW8, VXRM_RNE, 64'h0000_0000_0080_0002, "rne");
        do_single(0, 64'h0000_0000_00FF_0103, SEW8, VXRM_RDN, 64'h0000_0000_007F_0001, "rdn");
        do_single(0, 64'h0000_0000_00FF_0103, SEW8, VXRM_ROD, 64'h0000_0000_007F_0101, "rod");
        // Wider elements
        do_single(0, 64'h0003, SEW16, VXRM_RNU, 64'h0002, "hw");
        do_single(0, 64'h0103, SEW16, VXRM_RNU, 64'h0082, "hw_nocarry");
        do_single(0, 64'h8000_0001_0000_0003, SEW32, VXRM_RNU, 64'h4000_0001_0000_0002, "w32");
        do_single(1, 64'hFFFF_FFFF_FFFF_FFFF, SEW64, VXRM_RNE, 64'h8000_0000_0000_0000, "d64");

        // Round-robin with both requesters continuously valid
        req_valid = 2'b11;
        req_data  = {64'h5, 64'h0000_0000_00FF_0103};
        req_sew   = {SEW8, SEW8};
        req_vxrm  = {VXRM_RDN, VXRM_RNU};
        #1;
        for (int n = 0; n < 8; n++) begin
            check("rr_grant", 64'(req_ready), (n % 2 == 0) ? 64'd1 : 64'd2);
            if (n >= 2) begin
                check("rr_valid", 64'(out_valid), 64'd1);
                check("rr_id", 64'(out_id), 64'(n % 2));
                check("rr_data", out_data, (n % 2 == 0) ? 64'h0000_0000_0080_0102 : 64'h2);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rr_drained", 64'(out_valid), 64'd0);

        // Credit limit under backpressure
        out_ready = 1'b0;
        g = 0;
        req_valid = 2'b01;
        req_sew = '0; req_vxrm = '0;
        req_data[63:0] = cd[0];
        #1;
        for (int n = 0; n < 8; n++) begin
            if (req_ready[0]) g++;
            @(posedge clk); #1;
            if (g < 3) req_data[63:0] = cd[g];
        end
        check("credit_grants", 64'(g), 64'd3);
        check("credit_ready", 64'(req_ready), 64'd0);
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, ce[0]);
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_data", out_data, ce[i]);
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset with FIFO=2, inflight=1
        out_ready = 1'b0;
        g = 0;
        req_valid = 2'b01;
        req_data[63:0] = cd[0];
        #1;
        for (int n = 0; n < 10 && g < 3; n++) begin
            if (req_ready[0]) g++;
            @(posedge clk); #1;
            if (g < 3) req_data[63:0] = cd[g];
        end
        req_valid = '0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", out_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        do_single(0, 64'h0707, SEW8, VXRM_RNU, 64'h0404, "post_rst");
        check("post_rst_empty", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
